// File: rtl/sensor_inject_pkg.sv
// Shared definitions for the sensor frame packer: FSM states, header layout
// and the default header magic.
package sensor_inject_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2
    } state_e;

    localparam logic [15:0] MAGIC_DEFAULT = 16'hF5A5;

    // Header word layout: frame number on top, magic, then cells per frame.
    localparam int HDR_FRAME_LSB = 32;
    localparam int HDR_MAGIC_LSB = 16;
    localparam int HDR_CELLS_LSB = 0;

    function automatic logic [63:0] make_header(input logic [31:0] frame_num,
                                                 input logic [15:0] magic,
                                                 input logic [15:0] cells);
        logic [63:0] hdr;
        hdr = '0;
        hdr[HDR_FRAME_LSB +: 32] = frame_num;
        hdr[HDR_MAGIC_LSB +: 16] = magic;
        hdr[HDR_CELLS_LSB +: 16] = cells;
        return hdr;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI-Stream output holding register (64-bit data plus tlast).
// Accepts a new word whenever it is empty or its current word drains in the
// same cycle, so back-to-back loads run at full throughput.
module axis_out_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic [63:0] data_i,
    input  logic        last_i,
    output logic        ready_o,
    output logic [63:0] tdata_o,
    output logic        tvalid_o,
    output logic        tlast_o,
    input  logic        tready_i
);

    logic [63:0] data_q;
    logic        valid_q;
    logic        last_q;

    // Room for a new word: empty, or the held word leaves this cycle.
    assign ready_o = !valid_q || tready_i;

    // Hold the beat until the consumer takes it; reload in the draining cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (load_i && ready_o) begin
            // NOTE: non-blocking assignments here so every register samples the pre-edge values of its neighbours.
            data_q  <= data_i;
            valid_q <= 1'b1;
            last_q  <= last_i;
        end else if (tready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign tdata_o  = data_q;
    assign tvalid_o = valid_q;
    assign tlast_o  = last_q;

endmodule

// File: rtl/sensor_frame_packer.sv
// Packs a byte stream of sensor cells into 64-bit little-endian words,
// prefixing each frame with a header word carrying the frame number, the
// magic constant and the frame length in cells.
module sensor_frame_packer
    import sensor_inject_pkg::*;
#(
    parameter int unsigned CELLS_PER_FRAME = 2048,
    parameter logic [15:0] MAGIC           = MAGIC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_ENABLE,
    output logic        o_BUSY,
    output logic [31:0] o_FRAME_COUNT,
    input  logic [7:0]  axis_vector_tdata,
    input  logic        axis_vector_tvalid,
    output logic        axis_vector_tready,
    output logic [63:0] axis_frame_tdata,
    output logic        axis_frame_tvalid,
    output logic        axis_frame_tlast,
    input  logic        axis_frame_tready
);

    localparam logic [15:0] CELLS_FIELD = 16'(CELLS_PER_FRAME);
    localparam logic [15:0] LAST_CELL   = 16'(CELLS_PER_FRAME - 1);

    state_e      state_q, state_d;
    logic [2:0]  lane_q, lane_d;
    logic [15:0] cell_q, cell_d;
    logic [55:0] buf_q, buf_d;
    logic [31:0] frame_count_q, frame_count_d;

    logic        out_ready;
    logic        out_load;
    logic [63:0] out_data;
    logic        out_last;
    logic        vec_ready;
    logic        beat_last;

    // A frame is counted when its tlast beat actually transfers downstream.
    assign beat_last     = axis_frame_tvalid && axis_frame_tready && axis_frame_tlast;
    assign frame_count_d = frame_count_q + 32'(beat_last);

    // Next-state and datapath decode for IDLE -> HEADER -> DATA -> IDLE.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves one unassigned and infers a latch.
        state_d   = state_q;
        lane_d    = lane_q;
        cell_d    = cell_q;
        buf_d     = buf_q;
        out_load  = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        vec_ready = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_ENABLE && out_ready) begin
                    state_d = ST_HEADER;
                end
            end
            ST_HEADER: begin
                // Sample the count including a tlast draining this same cycle.
                if (out_ready) begin
                    out_load = 1'b1;
                    out_data = make_header(frame_count_d, MAGIC, CELLS_FIELD);
                    state_d  = ST_DATA;
                end
            end
            ST_DATA: begin
                // The 8th byte completes a word and needs room in the output register.
                vec_ready = !((lane_q == 3'd7) && !out_ready);
                if (axis_vector_tvalid && vec_ready) begin
                    cell_d = cell_q + 16'd1;
                    if (lane_q == 3'd7) begin
                        out_load = 1'b1;
                        out_data = {axis_vector_tdata, buf_q};
                        out_last = (cell_q == LAST_CELL);
                        lane_d   = 3'd0;
                        if (cell_q == LAST_CELL) begin
                            cell_d  = 16'd0;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        buf_d[{lane_q, 3'b000} +: 8] = axis_vector_tdata;
                        lane_d = lane_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and the partial-word buffer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the byte buffer is plain flops, so it is cleared with the rest; a reset also discards any partial word.
            state_q       <= ST_IDLE;
            lane_q        <= 3'd0;
            cell_q        <= 16'd0;
            buf_q         <= '0;
            frame_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            lane_q        <= lane_d;
            cell_q        <= cell_d;
            buf_q         <= buf_d;
            frame_count_q <= frame_count_d;
        end
    end

    axis_out_reg u_out_reg (
        .clk      (clk),
        .reset    (reset),
        .load_i   (out_load),
        .data_i   (out_data),
        .last_i   (out_last),
        .ready_o  (out_ready),
        .tdata_o  (axis_frame_tdata),
        .tvalid_o (axis_frame_tvalid),
        .tlast_o  (axis_frame_tlast),
        .tready_i (axis_frame_tready)
    );

    assign axis_vector_tready = vec_ready;
    assign o_BUSY             = (state_q != ST_IDLE);
    assign o_FRAME_COUNT      = frame_count_q;

endmodule
